// File: rtl/go_kill_conditioner.sv
// Conditions raw go/kill push-button levels for the downstream counter FSM.
// Each input is synchronised and debounced. Go becomes a single start pulse, and each started run is tracked to completion.
module go_kill_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 128
) (
    input  logic i_clk,
    input  logic reset,
    input  logic i_go_raw,
    input  logic i_kill_raw,
    input  logic i_done,
    output logic o_go,
    output logic o_kill,
    output logic o_busy,
    output logic o_timeout
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Channel index 0 is go, index 1 is kill.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stb;
    logic [DW-1:0] cnt [2];

    logic          go_stb;
    logic          kill_stb;
    logic          go_prev;
    logic          go_rise;
    logic [1:0]    state;
    logic [TW-1:0] timer;

    assign raw      = {i_kill_raw, i_go_raw};
    assign go_stb   = stb[0];
    assign kill_stb = stb[1];
    assign go_rise  = go_stb & ~go_prev;

    // A level must stay different from the stable value for DEBOUNCE_CYCLES edges
    // in a row before it is accepted. Any return to the stable value restarts the count.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            stb   <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                cnt[ch] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int ch = 0; ch < 2; ch++) begin
                if (sync2[ch] == stb[ch]) begin
                    cnt[ch] <= '0;
                end else if (cnt[ch] == DEB_LAST) begin
                    stb[ch] <= sync2[ch];
                    cnt[ch] <= '0;
                end else begin
                    cnt[ch] <= cnt[ch] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            go_prev   <= 1'b0;
            o_go      <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            go_prev   <= go_stb;
            // NOTE: default the pulse outputs low here so that every branch below only has to raise them.
            o_go      <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go_rise && !kill_stb) begin
                        o_go  <= 1'b1;
                        timer <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Priority order: kill first, then done, then the watchdog.
                    if (kill_stb) begin
                        state <= S_HOLD;
                    end else if (i_done) begin
                        state <= S_IDLE;
                    end else if (timer == TMO_LAST) begin
                        o_timeout <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!kill_stb) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (state != S_IDLE);
    assign o_kill = kill_stb;

endmodule

// File: tb/tb_go_kill_conditioner.sv
// Randomised and directed bench for go_kill_conditioner. A cycle-level reference model is built from the input-to-output rules.
module tb_go_kill_conditioner;

    localparam int DEB = 4;
    localparam int TMO = 8;

    logic i_clk = 1'b0;
    logic reset = 1'b1;
    logic i_go_raw = 1'b0;
    logic i_kill_raw = 1'b0;
    logic i_done = 1'b0;
    logic o_go, o_kill, o_busy, o_timeout;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    go_kill_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk     (i_clk),
        .reset     (reset),
        .i_go_raw  (i_go_raw),
        .i_kill_raw(i_kill_raw),
        .i_done    (i_done),
        .o_go      (o_go),
        .o_kill    (o_kill),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. The input delay line is two edges deep. A level is accepted once the last DEB
    // samples all disagree with the accepted value. A run is either idle, running (started at cycle
    // m_go_cyc), or held by kill.
    bit [1:0] m_s1, m_s2, m_stb;
    bit       win_go[$];
    bit       win_kill[$];
    bit       m_go_prev;
    int       m_mode;        // 0 idle, 1 running, 2 held by kill
    int       m_cyc;
    int       m_go_cyc;
    bit       m_go, m_to;

    function automatic bit all_differ(input bit q[$], input bit v);
        foreach (q[i]) if (q[i] == v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit [1:0] old_stb;
        bit       rise;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stb = '0;
            win_go.delete(); win_kill.delete();
            m_go_prev = 1'b0; m_mode = 0; m_go = 1'b0; m_to = 1'b0;
        end else begin
            old_stb = m_stb;
            rise = old_stb[0] & ~m_go_prev;
            m_go = 1'b0;
            m_to = 1'b0;
            case (m_mode)
                0: if (rise && !old_stb[1]) begin m_go = 1'b1; m_mode = 1; m_go_cyc = m_cyc; end
                1: begin
                    if (old_stb[1]) m_mode = 2;
                    else if (i_done) m_mode = 0;
                    else if (m_cyc - m_go_cyc == TMO) begin m_to = 1'b1; m_mode = 0; end
                end
                default: if (!old_stb[1]) m_mode = 0;
            endcase
            m_go_prev = old_stb[0];
            win_go.push_back(m_s2[0]);
            if (win_go.size() > DEB) void'(win_go.pop_front());
            if (win_go.size() == DEB && all_differ(win_go, old_stb[0])) begin
                m_stb[0] = ~old_stb[0];
                win_go.delete();
            end
            win_kill.push_back(m_s2[1]);
            if (win_kill.size() > DEB) void'(win_kill.pop_front());
            if (win_kill.size() == DEB && all_differ(win_kill, old_stb[1])) begin
                m_stb[1] = ~old_stb[1];
                win_kill.delete();
            end
            m_s2 = m_s1;
            m_s1 = {i_kill_raw, i_go_raw};
        end
        m_cyc++;
    endtask

    // One clock edge: advance the model, then compare all outputs 1 time unit after the edge.
    task automatic step();
        model_edge();
        @(posedge i_clk);
        #1;
        check("o_go", o_go, m_go);
        check("o_timeout", o_timeout, m_to);
        check("o_kill", o_kill, m_stb[1]);
        check("o_busy", o_busy, m_mode != 0);
    endtask

    task automatic settle_low();
        i_go_raw = 1'b0;
        i_kill_raw = 1'b0;
        i_done = 1'b0;
        repeat (16) step();
    endtask

    // The go level is accepted at relative edge 6 (o_go at 7). It drops at edge 10 and is accepted high again at edge 14.
    // That new rise reaches the FSM at edge 15, which is also the watchdog expiry edge.
    task automatic retrigger_run(input bit done_at_14);
        int pulses;
        pulses = 0;
        i_go_raw = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            step();
            if (e == 7) check("retrig_first_go", o_go, 1'b1);
            if (e >= 8 && o_go) pulses++;
            if (e == 4) i_go_raw = 1'b0;
            if (e == 8) i_go_raw = 1'b1;
            if (e == 13) i_done = done_at_14;
            if (e == 14) i_done = 1'b0;
            if (e == 15) check("retrig_timeout_e15", o_timeout, !done_at_14);
        end
        check("retrig_second_go", pulses, done_at_14 ? 1 : 0);
    endtask

    initial begin
        int go_hold, kill_hold, glitch_go;

        // Reset with both buttons held high.
        reset = 1'b1;
        i_go_raw = 1'b1;
        i_kill_raw = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 5) check("kill_before_e6", o_kill, 1'b0);
            if (e == 6) check("kill_at_e6", o_kill, 1'b1);
            check("go_blocked_by_kill", o_go, 1'b0);
        end
        settle_low();

        // Clean go, then done.
        i_go_raw = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 6) check("busy_before_go", o_busy, 1'b0);
            if (e == 7) begin
                check("clean_go_e7", o_go, 1'b1);
                check("clean_busy_e7", o_busy, 1'b1);
            end
            if (e == 9) i_done = 1'b1;
            if (e == 10) begin
                i_done = 1'b0;
                check("done_busy_e10", o_busy, 1'b0);
            end
        end
        settle_low();

        // Go glitch shorter than the debounce window.
        glitch_go = 0;
        i_go_raw = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e == 3) i_go_raw = 1'b0;
            if (o_go) glitch_go++;
        end
        check("glitch_no_go", glitch_go, 0);

        // Watchdog expiry, and re-trigger with and without done.
        settle_low();
        retrigger_run(1'b0);
        settle_low();
        retrigger_run(1'b1);
        settle_low();

        // Kill during a run.
        i_go_raw = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            step();
            if (e == 7) i_kill_raw = 1'b1;
            if (e == 16) begin
                check("hold_kill", o_kill, 1'b1);
                check("hold_busy", o_busy, 1'b1);
            end
        end
        i_kill_raw = 1'b0;
        i_go_raw = 1'b0;
        repeat (8) step();
        check("kill_release_busy", o_busy, 1'b0);
        i_go_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 7) check("go_after_kill", o_go, 1'b1);
        end
        settle_low();

        // Randomised phase.
        go_hold = 1;
        kill_hold = 30;
        for (int c = 0; c < 3000; c++) begin
            if (--go_hold <= 0) begin
                i_go_raw = ~i_go_raw;
                go_hold = $urandom_range(1, 14);
            end
            if (--kill_hold <= 0) begin
                i_kill_raw = ~i_kill_raw;
                kill_hold = i_kill_raw ? $urandom_range(1, 20) : $urandom_range(1, 70);
            end
            i_done = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 1'b0;
        i_done = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/go_kill_conditioner.md
# go_kill_conditioner

Front-end stage that turns raw, asynchronous go/kill push-button levels into the clean control inputs the downstream counter state machine consumes. Each input is synchronised and debounced. Go is reduced to a single-cycle start pulse, and kill is delivered as a debounced level. An issue FSM tracks each started run until the downstream done pulse, a kill, or a watchdog timeout, and suppresses new go pulses while a run is outstanding.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its stable value before the stable value flips (≥2)
- TIMEOUT_CYCLES, 128, watchdog length in cycles for an outstanding run (≥2; must exceed downstream run length of 102 cycles)
- i_clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high; sampled on posedge i_clk only
- i_go_raw  in  1  asynchronous go button level
- i_kill_raw  in  1  asynchronous kill button level
- i_done  in  1  one-cycle done pulse from downstream, synchronous to i_clk
- o_go  out  1  one-cycle start pulse to downstream i_go
- o_kill  out  1  debounced kill level to downstream i_kill
- o_busy  out  1  high while a run is outstanding
- o_timeout  out  1  one-cycle pulse when the watchdog expires

## Operation
- Reset: sync flops, stable values, counters and timer are cleared; the FSM enters S_IDLE. o_go, o_kill, o_busy and o_timeout are all 0. Reset mid-debounce or mid-run discards all progress.
- Synchroniser: each raw input feeds a 2-flop chain (sync1 then sync2).
- Debounce, per channel. Stable register `stb` and counter `cnt`, width $clog2(DEBOUNCE_CYCLES).
  - Each edge where sync2 == stb: cnt <= 0.
  - Each edge where sync2 != stb: if cnt == DEBOUNCE_CYCLES-1, then stb <= sync2 and cnt <= 0; otherwise cnt++.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stb.
- o_kill is the kill channel's stb register.
- Go edge: go_prev registers go stb each cycle. go_rise = go_stb & ~go_prev.
- Issue FSM:
  - S_IDLE, o_busy=0: if go_rise & ~kill_stb, then o_go <= 1, timer <= 0 and go to S_WAIT. A go_rise while kill_stb is high is dropped. i_done is ignored.
  - S_WAIT, o_busy=1. Priority is kill > done > timeout:
    - kill_stb: go to S_HOLD.
    - i_done: go to S_IDLE.
    - timer == TIMEOUT_CYCLES-1: o_timeout <= 1, go to S_IDLE.
    - Otherwise timer++.
    - go_rise is ignored (no re-trigger, no queueing).
  - S_HOLD, o_busy=1: when kill_stb == 0, go to S_IDLE. This mirrors the downstream abort state.
- o_go and o_timeout are registered and deassert on the following edge.
- Timer width is $clog2(TIMEOUT_CYCLES); it cannot wrap, because it only counts in S_WAIT and exits at TIMEOUT_CYCLES-1.
- A raw input held high through reset is treated as a new rise after release, because stb resets to 0.

## Timing
Edge numbering: the raw input changes before edge 1, and edge 1 is the first edge at which sync1 captures it.

Input path:
- sync2 updates at edge 2.
- Debounce cnt advances at edges 3 through 1+DEBOUNCE_CYCLES.
- stb flips at edge 2+DEBOUNCE_CYCLES.
- o_kill latency: rises or falls at edge DEBOUNCE_CYCLES+2.
- o_go latency: rises at edge DEBOUNCE_CYCLES+3 (a cycle later than o_kill) and is high for exactly one cycle.

Issue FSM:
- o_busy rises on the same edge as o_go and falls on the edge that leaves S_WAIT or S_HOLD.
- i_done sampled high at edge n in S_WAIT: o_busy is 0 after edge n. A new go is accepted from edge n+1.
- Watchdog: o_timeout rises at edge e+TIMEOUT_CYCLES, where e is the edge that raised o_go. o_busy falls on that same edge.
- i_done and kill_stb high on the same edge in S_WAIT: go to S_HOLD.
- i_done and timer expiry on the same edge: go to S_IDLE with no o_timeout.

## Test plan
- **Reset values:** apply reset for 3 cycles with both raw inputs high → all outputs 0 during reset. After release with DEBOUNCE_CYCLES=4, o_kill rises at edge 6 (edge 1 = first edge after release) and o_go stays 0, because kill is active.
- **Clean go:** DEBOUNCE_CYCLES=4, i_go_raw high for 20 cycles → o_go pulses once at edge 7 and o_busy rises at edge 7. i_done pulse at edge 30 → o_busy falls at edge 30.
- **Glitch rejection:** DEBOUNCE_CYCLES=4, i_go_raw pulsed high for 3 cycles → o_go never asserts, and go stb stays 0.
- **Re-trigger blocked:** second debounced go rise while in S_WAIT → no second o_go. A go rise one cycle after i_done → o_go accepted.
- **Kill during run:** debounced kill while in S_WAIT → o_kill high and FSM in S_HOLD with o_busy=1. Kill release (after debounce) → o_busy 0; a subsequent go is accepted.
- **Watchdog:** TIMEOUT_CYCLES=8 with i_done never asserted → o_timeout pulses exactly 8 edges after o_go and o_busy falls on that same edge. Repeat with i_done on the expiry edge → no o_timeout.
